// File: rtl/device_arbiter.sv
// rtl/device_arbiter.sv - round-robin arbiter sharing one single-outstanding device port
// between NumHosts hosts, with response routing and a response watchdog.
module device_arbiter #(
  parameter int NumHosts      = 2,
  parameter int TimeoutCycles = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHosts-1:0]      host_req_i,
  input  logic [NumHosts*32-1:0]   host_addr_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [NumHosts*4-1:0]    host_be_i,
  input  logic [NumHosts*32-1:0]   host_wdata_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [NumHosts-1:0]      host_err_o,
  output logic [31:0]              host_rdata_o,
  output logic                     device_req_o,
  output logic [31:0]              device_addr_o,
  output logic                     device_we_o,
  output logic [3:0]               device_be_o,
  output logic [31:0]              device_wdata_o,
  input  logic                     device_rvalid_i,
  input  logic [31:0]              device_rdata_i,
  output logic [7:0]               timeout_cnt_o
);

  localparam int IdxW  = $clog2(NumHosts);
  localparam int CandW = IdxW + 1;
  localparam int CntW  = $clog2(TimeoutCycles + 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]       timeout_cnt_q, timeout_cnt_d;

  logic             resp_ok, timeout_hit, free, gnt_valid, grant;
  logic [IdxW-1:0]  win;
  logic [CandW-1:0] cand;

  assign resp_ok     = (state_q == WAIT) && device_rvalid_i;
  assign timeout_hit = (state_q == WAIT) && !device_rvalid_i &&
                       (wait_cnt_q == CntW'(TimeoutCycles));
  assign free        = (state_q == IDLE) || resp_ok;
  assign grant       = free && gnt_valid;

  // Search order starts just after the last winner and wraps around.
  always_comb begin
    gnt_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int i = 1; i <= NumHosts; i++) begin
      cand = {1'b0, last_q} + CandW'(i);
      if (cand >= CandW'(NumHosts)) cand = cand - CandW'(NumHosts);
      if (!gnt_valid && host_req_i[cand[IdxW-1:0]]) begin
        gnt_valid = 1'b1;
        win       = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    host_gnt_o     = '0;
    host_rvalid_o  = '0;
    host_err_o     = '0;
    host_rdata_o   = '0;
    device_req_o   = 1'b0;
    device_addr_o  = '0;
    device_we_o    = 1'b0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (!rst_i) begin
      if (grant) begin
        host_gnt_o[win] = 1'b1;
        device_req_o    = 1'b1;
        for (int h = 0; h < NumHosts; h++) begin
          if (win == IdxW'(h)) begin
            device_addr_o  = host_addr_i[h*32 +: 32];
            device_we_o    = host_we_i[h];
            device_be_o    = host_be_i[h*4 +: 4];
            device_wdata_o = host_wdata_i[h*32 +: 32];
          end
        end
      end
      if (resp_ok || timeout_hit) host_rvalid_o[owner_q] = 1'b1;
      if (timeout_hit)            host_err_o[owner_q]    = 1'b1;
      if (resp_ok)                host_rdata_o           = device_rdata_i;
    end
  end

  assign timeout_cnt_o = rst_i ? 8'd0 : timeout_cnt_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (free) begin
      if (gnt_valid) begin
        state_d    = WAIT;
        owner_d    = win;
        last_d     = win;
        wait_cnt_d = '0;
      end else begin
        state_d = IDLE;
      end
    end else if (timeout_hit) begin
      // A response arriving after this point is dropped as stray.
      state_d = IDLE;
      if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
    end else if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_q        <= IdxW'(NumHosts - 1);
      wait_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

endmodule

// File: tb/tb_device_arbiter.sv
// tb/tb_device_arbiter.sv - directed vector table, hand sequences and randomized run
// against a transaction-level model of device_arbiter.
module tb_device_arbiter;
  localparam int N  = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  h_req, h_we;
  logic [N*32-1:0] h_addr, h_wdata;
  logic [N*4-1:0]  h_be;
  logic [N-1:0]  gnt, hrv, herr;
  logic [31:0]   hrd;
  logic          dreq, dwe, rv;
  logic [31:0]   daddr, dwdata, rd;
  logic [3:0]    dbe;
  logic [7:0]    tcnt;

  device_arbiter #(.NumHosts(N), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(h_req), .host_addr_i(h_addr), .host_we_i(h_we),
    .host_be_i(h_be), .host_wdata_i(h_wdata),
    .host_gnt_o(gnt), .host_rvalid_o(hrv), .host_err_o(herr), .host_rdata_o(hrd),
    .device_req_o(dreq), .device_addr_o(daddr), .device_we_o(dwe),
    .device_be_o(dbe), .device_wdata_o(dwdata),
    .device_rvalid_i(rv), .device_rdata_i(rd),
    .timeout_cnt_o(tcnt)
  );

  int tests = 0;
  int fails = 0;

  // Model: one outstanding transaction, its owner and its age in cycles since grant.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_age   = 0;
  int m_last  = N - 1;
  int m_tocnt = 0;

  logic [N-1:0] s_gnt, s_hrv, s_err;
  logic [31:0]  s_hrd, s_daddr, s_dwdata;
  logic         s_dreq, s_dwe;
  logic [3:0]   s_dbe;
  logic [7:0]   s_tcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    int win;
    bit resp, tmo, fr;
    logic [N-1:0] e_gnt, e_hrv, e_err;
    logic [31:0] e_hrd, e_addr, e_wd;
    logic e_req, e_we;
    logic [3:0] e_be;
    logic [7:0] e_tc;
    bit n_busy; int n_owner, n_age, n_last, n_tocnt;
    @(negedge clk);
    s_gnt = gnt; s_hrv = hrv; s_err = herr; s_hrd = hrd; s_dreq = dreq;
    s_daddr = daddr; s_dwe = dwe; s_dbe = dbe; s_dwdata = dwdata; s_tcnt = tcnt;
    e_gnt = '0; e_hrv = '0; e_err = '0; e_hrd = '0; e_addr = '0; e_wd = '0;
    e_req = 1'b0; e_we = 1'b0; e_be = '0; e_tc = '0;
    n_busy = m_busy; n_owner = m_owner; n_age = m_age; n_last = m_last; n_tocnt = m_tocnt;
    if (rst) begin
      n_busy = 1'b0; n_last = N - 1; n_tocnt = 0; n_age = 0;
    end else begin
      resp = m_busy && rv;
      tmo  = m_busy && !rv && (m_age == TO + 1);
      fr   = !m_busy || rv;
      win  = -1;
      if (fr)
        for (int k = 1; k <= N; k++)
          if (win < 0 && h_req[(m_last + k) % N]) win = (m_last + k) % N;
      if (win >= 0) begin
        e_gnt[win] = 1'b1; e_req = 1'b1;
        e_addr = h_addr[win*32 +: 32]; e_we = h_we[win];
        e_be = h_be[win*4 +: 4]; e_wd = h_wdata[win*32 +: 32];
      end
      if (resp || tmo) e_hrv[m_owner] = 1'b1;
      if (tmo) e_err[m_owner] = 1'b1;
      if (resp) e_hrd = rd;
      e_tc = 8'(m_tocnt);
      if (win >= 0) begin
        n_busy = 1'b1; n_owner = win; n_last = win; n_age = 1;
      end else if (fr) begin
        n_busy = 1'b0;
      end else if (tmo) begin
        n_busy = 1'b0;
        n_tocnt = (m_tocnt < 255) ? m_tocnt + 1 : 255;
      end else begin
        n_age = m_age + 1;
      end
    end
    chk("gnt", s_gnt, e_gnt);
    chk("rvalid", s_hrv, e_hrv);
    chk("err", s_err, e_err);
    chk("rdata", s_hrd, e_hrd);
    chk("dev_req", s_dreq, e_req);
    chk("dev_addr", s_daddr, e_addr);
    chk("dev_we", s_dwe, e_we);
    chk("dev_be", s_dbe, e_be);
    chk("dev_wdata", s_dwdata, e_wd);
    chk("timeout_cnt", s_tcnt, e_tc);
    @(posedge clk);
    m_busy = n_busy; m_owner = n_owner; m_age = n_age; m_last = n_last; m_tocnt = n_tocnt;
    #1;
  endtask

  typedef struct {
    logic rst; logic [1:0] req; logic rv; logic [31:0] rd;
    logic [1:0] gnt; logic [1:0] hrv; logic [1:0] err; logic [31:0] hrd; logic [7:0] tc;
  } vec_t;

  vec_t tbl[28];

  initial begin
    //          rst req   rv rd             gnt   hrv   err   hrd            tc
    tbl[0]  = '{1, 2'b00, 0, 32'h0,        2'b00,2'b00,2'b00,32'h0,        8'd0};
    tbl[1]  = '{0, 2'b01, 0, 32'h0,        2'b01,2'b00,2'b00,32'h0,        8'd0};
    tbl[2]  = '{0, 2'b00, 1, 32'hDEAD,     2'b00,2'b01,2'b00,32'hDEAD,     8'd0};
    tbl[3]  = '{1, 2'b00, 0, 32'h0,        2'b00,2'b00,2'b00,32'h0,        8'd0};
    tbl[4]  = '{0, 2'b11, 0, 32'h0,        2'b01,2'b00,2'b00,32'h0,        8'd0};
    tbl[5]  = '{0, 2'b11, 1, 32'h1,        2'b10,2'b01,2'b00,32'h1,        8'd0};
    tbl[6]  = '{0, 2'b11, 1, 32'h2,        2'b01,2'b10,2'b00,32'h2,        8'd0};
    tbl[7]  = '{0, 2'b11, 1, 32'h3,        2'b10,2'b01,2'b00,32'h3,        8'd0};
    tbl[8]  = '{0, 2'b10, 1, 32'h4,        2'b10,2'b10,2'b00,32'h4,        8'd0};
    tbl[9]  = '{0, 2'b00, 1, 32'h5,        2'b00,2'b10,2'b00,32'h5,        8'd0};
    tbl[10] = '{0, 2'b10, 0, 32'h0,        2'b10,2'b00,2'b00,32'h0,        8'd0};
    tbl[11] = '{0, 2'b01, 0, 32'h0,        2'b00,2'b00,2'b00,32'h0,        8'd0};
    tbl[12] = '{0, 2'b01, 0, 32'h0,        2'b00,2'b00,2'b00,32'h0,        8'd0};
    tbl[13] = '{0, 2'b01, 1, 32'h12345678, 2'b01,2'b10,2'b00,32'h12345678, 8'd0};
    tbl[14] = '{0, 2'b00, 1, 32'h7,        2'b00,2'b01,2'b00,32'h7,        8'd0};
    tbl[15] = '{0, 2'b01, 0, 32'h0,        2'b01,2'b00,2'b00,32'h0,        8'd0};
    for (int i = 16; i <= 19; i++)
      tbl[i] = '{0, 2'b00, 0, 32'h0,       2'b00,2'b00,2'b00,32'h0,        8'd0};
    tbl[20] = '{0, 2'b00, 0, 32'h0,        2'b00,2'b01,2'b01,32'h0,        8'd0};
    tbl[21] = '{0, 2'b00, 1, 32'hBAD,      2'b00,2'b00,2'b00,32'h0,        8'd1};
    tbl[22] = '{0, 2'b10, 0, 32'h0,        2'b10,2'b00,2'b00,32'h0,        8'd1};
    for (int i = 23; i <= 26; i++)
      tbl[i] = '{0, 2'b00, 0, 32'h0,       2'b00,2'b00,2'b00,32'h0,        8'd1};
    tbl[27] = '{0, 2'b00, 1, 32'h55,       2'b00,2'b10,2'b00,32'h55,       8'd1};

    rst = 1'b1; h_req = '0; rv = 1'b0; rd = '0;
    h_addr  = {32'h0000_0100, 32'h0000_0000};
    h_we    = 2'b01;
    h_be    = {4'hF, 4'h3};
    h_wdata = {32'h0, 32'h0000_A5A5};

    for (int i = 0; i < 28; i++) begin
      rst = tbl[i].rst; h_req = tbl[i].req; rv = tbl[i].rv; rd = tbl[i].rd;
      step();
      chk($sformatf("tbl%0d_gnt", i), s_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_rvalid", i), s_hrv, tbl[i].hrv);
      chk($sformatf("tbl%0d_err", i), s_err, tbl[i].err);
      chk($sformatf("tbl%0d_rdata", i), s_hrd, tbl[i].hrd);
      chk($sformatf("tbl%0d_tcnt", i), s_tcnt, tbl[i].tc);
      if (i == 1) begin
        chk("write_dev_addr", s_daddr, 32'h0);
        chk("write_dev_be", s_dbe, 4'h3);
        chk("write_dev_wdata", s_dwdata, 32'h0000_A5A5);
        chk("write_dev_we", s_dwe, 1'b1);
      end
    end

    // Reset in the middle of an outstanding transaction.
    rst = 1'b0; h_req = 2'b01; rv = 1'b0;
    step();
    chk("rstwait_gnt", s_gnt, 2'b01);
    h_req = 2'b00;
    step();
    rst = 1'b1; rv = 1'b1; rd = 32'h99;
    step();
    chk("rstwait_rvalid", s_hrv, 2'b00);
    chk("rstwait_dreq", s_dreq, 1'b0);
    chk("rstwait_rdata", s_hrd, 32'h0);
    rst = 1'b0; h_req = 2'b01; rv = 1'b1;
    step();
    chk("postrst_gnt", s_gnt, 2'b01);
    chk("postrst_rvalid", s_hrv, 2'b00);
    h_req = 2'b00; rd = 32'h1;
    step();
    rv = 1'b0;

    // Timeout counter saturation.
    for (int n = 0; n < 300; n++) begin
      h_req = 2'b01;
      step();
      h_req = 2'b00;
      for (int c = 0; c <= TO; c++) step();
    end
    step();
    chk("tcnt_saturated", s_tcnt, 8'd255);

    // Randomized traffic; requests are held until granted.
    for (int n = 0; n < 2000; n++) begin
      for (int h = 0; h < N; h++) begin
        if (!h_req[h] || s_gnt[h]) begin
          h_req[h] = 1'($urandom_range(0, 1));
          h_addr[h*32 +: 32] = $urandom;
          h_we[h] = 1'($urandom_range(0, 1));
          h_be[h*4 +: 4] = 4'($urandom_range(0, 15));
          h_wdata[h*32 +: 32] = $urandom;
        end
      end
      rv  = ($urandom_range(0, 9) < 4);
      rd  = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
